// File: rtl/svc_uart_tx_arb.sv
// rtl/svc_uart_tx_arb.sv - message-granular round-robin arbiter for the UART TX byte stream
// A grant is held from the first byte of a message through its last byte or a stall timeout.
module svc_uart_tx_arb #(
    parameter int NUM_SRC        = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         s_valid,
    input  logic [NUM_SRC*8-1:0]       s_data,
    input  logic [NUM_SRC-1:0]         s_last,
    output logic [NUM_SRC-1:0]         s_ready,
    output logic                       m_valid,
    output logic [7:0]                 m_data,
    input  logic                       m_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   stall_q, stall_d;
    logic            timeout_q, timeout_d;

    logic [GW-1:0]   pick;
    logic            any_req;
    int              sel_idx;
    logic [GW-1:0]   next_ptr;
    logic            cur_valid;
    logic            cur_last;
    logic            handshake;
    logic            stall_hit;

    // Search upward from the pointer; wrap by compare so non-power-of-two counts work.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        sel_idx = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sel_idx = int'(rr_ptr_q) + k;
            if (sel_idx >= NUM_SRC) begin
                sel_idx = sel_idx - NUM_SRC;
            end
            if (!any_req && s_valid[sel_idx]) begin
                any_req = 1'b1;
                pick    = GW'(sel_idx);
            end
        end
    end

    assign next_ptr  = (grant_q == GW'(NUM_SRC - 1)) ? '0 : grant_q + GW'(1);
    assign cur_valid = s_valid[grant_q];
    assign cur_last  = s_last[grant_q];
    assign handshake = cur_valid & m_ready;
    assign stall_hit = (TIMEOUT_CYCLES != 0) && !cur_valid
                       && (stall_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    stall_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // UART backpressure with the source still valid leaves the stall count alone.
                if (handshake) begin
                    stall_d = '0;
                    if (cur_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!cur_valid) begin
                    if (stall_hit) begin
                        state_d   = IDLE;
                        rr_ptr_d  = next_ptr;
                        timeout_d = 1'b1;
                    end else begin
                        stall_d = stall_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == GRANT);
        m_valid  = busy & cur_valid;
        m_data   = s_data[8*int'(grant_q) +: 8];
        s_ready  = '0;
        if (busy) begin
            s_ready[grant_q] = m_ready;
        end
        grant_id = grant_q;
        timeout  = timeout_q;
    end

endmodule

// File: tb/tb_svc_uart_tx_arb.sv
// tb/tb_svc_uart_tx_arb.sv - self-checking bench for svc_uart_tx_arb (3 sources, timeout 8)
module tb_svc_uart_tx_arb;

    localparam int N = 3;
    localparam int T = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   s_valid;
    logic [N*8-1:0] s_data;
    logic [N-1:0]   s_last;
    logic [N-1:0]   s_ready;
    logic           m_valid;
    logic [7:0]     m_data;
    logic           m_ready;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout;

    svc_uart_tx_arb #(.NUM_SRC(N), .TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner of the stream (-1 when idle), fairness pointer,
    // consecutive non-valid cycles of the owner, and the pending timeout flag.
    int own;
    int ptr;
    int stall;
    bit tmo;

    typedef struct {
        logic [N-1:0]   sv;
        logic [N*8-1:0] sd;
        logic [N-1:0]   sl;
        logic           mr;
        logic           e_busy;
        logic           e_mv;
        logic [7:0]     e_md;
        logic [N-1:0]   e_sr;
        logic           e_to;
        logic [1:0]     e_g;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        own   = -1;
        ptr   = 0;
        stall = 0;
        tmo   = 1'b0;
    endtask

    task automatic model_check();
        logic [N-1:0] er;
        logic         ev;
        er = '0;
        ev = 1'b0;
        if (own >= 0) begin
            ev = s_valid[own];
            if (m_ready) er[own] = 1'b1;
        end
        chk("busy", 32'(busy), 32'(own >= 0));
        chk("m_valid", 32'(m_valid), 32'(ev));
        chk("s_ready", 32'(s_ready), 32'(er));
        chk("timeout", 32'(timeout), 32'(tmo));
        if (ev) chk("m_data", 32'(m_data), 32'(s_data[8*own +: 8]));
        if (own >= 0) chk("grant_id", 32'(grant_id), 32'(own));
    endtask

    task automatic model_step();
        int nxt;
        tmo = 1'b0;
        if (own < 0) begin
            nxt = -1;
            for (int k = 0; k < N; k++) begin
                if (nxt < 0 && s_valid[(ptr + k) % N]) nxt = (ptr + k) % N;
            end
            if (nxt >= 0) begin
                own   = nxt;
                stall = 0;
            end
        end else if (s_valid[own]) begin
            if (m_ready) begin
                stall = 0;
                if (s_last[own]) begin
                    ptr = (own + 1) % N;
                    own = -1;
                end
            end
        end else begin
            stall++;
            if (stall == T) begin
                tmo   = 1'b1;
                ptr   = (own + 1) % N;
                own   = -1;
                stall = 0;
            end
        end
    endtask

    task automatic tail();
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        tail();
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*8-1:0] d,
                         input logic [N-1:0] l, input logic r);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pos0, pos1, ng, pulses, first_to, after_g, idx;
        logic [1:0] grants[4];
        logic prev_busy, done0, hs0, hs1, stable;
        int pv, pr;

        tbl[0]  = '{3'b001, 24'h000048, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 2'd0};
        tbl[1]  = '{3'b001, 24'h000048, 3'b000, 1'b1, 1'b1, 1'b1, 8'h48, 3'b001, 1'b0, 2'd0};
        tbl[2]  = '{3'b001, 24'h000069, 3'b000, 1'b1, 1'b1, 1'b1, 8'h69, 3'b001, 1'b0, 2'd0};
        tbl[3]  = '{3'b001, 24'h00000A, 3'b001, 1'b1, 1'b1, 1'b1, 8'h0A, 3'b001, 1'b0, 2'd0};
        tbl[4]  = '{3'b010, 24'h003100, 3'b010, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 2'd0};
        tbl[5]  = '{3'b010, 24'h003100, 3'b010, 1'b1, 1'b1, 1'b1, 8'h31, 3'b010, 1'b0, 2'd1};
        tbl[6]  = '{3'b101, 24'h770055, 3'b101, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 2'd0};
        tbl[7]  = '{3'b101, 24'h770055, 3'b101, 1'b1, 1'b1, 1'b1, 8'h77, 3'b100, 1'b0, 2'd2};
        tbl[8]  = '{3'b101, 24'h780055, 3'b101, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 2'd0};
        tbl[9]  = '{3'b101, 24'h780055, 3'b101, 1'b1, 1'b1, 1'b1, 8'h55, 3'b001, 1'b0, 2'd0};
        tbl[10] = '{3'b100, 24'h780000, 3'b100, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 2'd0};
        tbl[11] = '{3'b100, 24'h780000, 3'b100, 1'b0, 1'b1, 1'b1, 8'h78, 3'b000, 1'b0, 2'd2};
        tbl[12] = '{3'b100, 24'h780000, 3'b100, 1'b1, 1'b1, 1'b1, 8'h78, 3'b100, 1'b0, 2'd2};
        tbl[13] = '{3'b000, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 2'd0};

        rst_n = 1'b0;
        drive('0, '0, '0, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        model_check();
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single message, back-to-back sources, pointer wrap, backpressure of one cycle.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr);
            @(negedge clk);
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            chk($sformatf("row%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_sr));
            chk($sformatf("row%0d_timeout", i), 32'(timeout), 32'(tbl[i].e_to));
            if (tbl[i].e_mv) chk($sformatf("row%0d_m_data", i), 32'(m_data), 32'(tbl[i].e_md));
            if (tbl[i].e_busy) chk($sformatf("row%0d_grant", i), 32'(grant_id), 32'(tbl[i].e_g));
            tail();
        end

        // Fairness: sources 0 and 1 stream 2-byte messages continuously.
        pos0 = 0; pos1 = 0; ng = 0; prev_busy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(3'b011, {8'h00, 8'hB0 + 8'(pos1), 8'hA0 + 8'(pos0)},
                  {1'b0, 1'(pos1), 1'(pos0)}, 1'b1);
            @(negedge clk);
            if (busy && !prev_busy && ng < 4) begin
                grants[ng] = grant_id;
                ng++;
            end
            prev_busy = busy;
            hs0 = s_ready[0] & s_valid[0];
            hs1 = s_ready[1] & s_valid[1];
            tail();
            if (hs0) pos0 = 1 - pos0;
            if (hs1) pos1 = 1 - pos1;
        end
        chk("fair_count", 32'(ng), 32'd4);
        for (int g = 0; g < 4; g++) chk($sformatf("fair_grant%0d", g), 32'(grants[g]), 32'(g % 2));
        drive('0, '0, '0, 1'b1);
        tick();

        // Long UART backpressure mid-message must not time out.
        drive(3'b001, 24'h000011, 3'b000, 1'b1);
        tick();
        tick();
        drive(3'b001, 24'h000022, 3'b001, 1'b0);
        pulses = 0; stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (timeout) pulses++;
            if (m_data !== 8'h22 || m_valid !== 1'b1) stable = 1'b0;
            tail();
        end
        chk("bp_no_timeout", 32'(pulses), 32'd0);
        chk("bp_data_stable", 32'(stable), 32'd1);
        m_ready = 1'b1;
        tick();
        drive('0, '0, '0, 1'b1);
        @(negedge clk);
        chk("bp_released", 32'(busy), 32'd0);
        tail();

        // Stall timeout: source 1 stops mid-message while source 0 waits.
        drive(3'b010, 24'h005A00, 3'b000, 1'b1);
        tick();
        tick();
        pulses = 0; first_to = -1; after_g = -1; done0 = 1'b0;
        for (int c = 0; c < 14; c++) begin
            drive(done0 ? 3'b000 : 3'b001, 24'h0000C3, 3'b001, 1'b1);
            @(negedge clk);
            if (timeout) begin
                pulses++;
                if (first_to < 0) first_to = c;
            end
            if (first_to >= 0 && busy && after_g < 0) after_g = int'(grant_id);
            if (s_ready[0] && s_valid[0]) done0 = 1'b1;
            tail();
        end
        chk("to_pulses", 32'(pulses), 32'd1);
        chk("to_cycle", 32'(first_to), 32'(T));
        chk("to_next_grant", 32'(after_g), 32'd0);

        // Wrap: only source 2, then 0 and 2 together -> 0.
        drive(3'b100, 24'hE10000, 3'b100, 1'b1);
        tick();
        tick();
        drive(3'b101, 24'hE200E0, 3'b101, 1'b1);
        tick();
        @(negedge clk);
        chk("wrap_grant", 32'(grant_id), 32'd0);
        tail();
        drive('0, '0, '0, 1'b1);
        tick();
        tick();

        // Asynchronous reset mid-message, then the pointer must restart at 0.
        drive(3'b010, 24'h001700, 3'b010, 1'b1);
        tick();
        tick();
        drive(3'b001, 24'h000099, 3'b000, 1'b1);
        tick();
        tick();
        #2;
        chk("pre_reset_mv", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        model_reset();
        drive('0, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(3'b110, 24'h343300, 3'b110, 1'b1);
        tick();
        @(negedge clk);
        chk("rst_ptr_grant", 32'(grant_id), 32'd1);
        tail();
        drive('0, '0, '0, 1'b1);
        tick();
        tick();

        // Randomized traffic against the model.
        for (int seg = 0; seg < 60; seg++) begin
            idx = int'($urandom_range(0, 2));
            pv  = (idx == 0) ? 25 : (idx == 1) ? 70 : 95;
            idx = int'($urandom_range(0, 2));
            pr  = (idx == 0) ? 50 : (idx == 1) ? 90 : 100;
            for (int c = 0; c < 50; c++) begin
                for (int s = 0; s < N; s++) begin
                    s_valid[s] = ($urandom_range(0, 99) < pv);
                    s_last[s]  = ($urandom_range(0, 99) < 35);
                end
                s_data  = 24'($urandom);
                m_ready = ($urandom_range(0, 99) < pr);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/svc_uart_tx_arb.md
# svc_uart_tx_arb

Message-granular round-robin arbiter that shares the single SoC UART transmit byte stream between several byte sources (CPU console MMIO, simulation reporter, debug monitor). It sits between the sources and the UART TX serializer. A grant is held for a whole message, up to and including the byte flagged `last`, so lines from different sources never interleave. A stall timeout reclaims the grant from a source that stops mid-message.

## Interface
Parameters:
- `NUM_SRC`, 2: number of byte sources; must be ≥ 2.
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles tolerated mid-message before the grant is revoked; 0 disables the timeout.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in NUM_SRC: per-source byte valid.
- `s_data` in NUM_SRC*8: per-source byte; source i occupies bits [8i+7:8i].
- `s_last` in NUM_SRC: per-source end-of-message flag, qualified by `s_valid`.
- `s_ready` out NUM_SRC: per-source ready.
- `m_valid` out 1: byte valid to the UART TX.
- `m_data` out 8: byte to the UART TX.
- `m_ready` in 1: UART TX accepts the byte.
- `grant_id` out $clog2(NUM_SRC): currently granted source; meaningful only while `busy`=1.
- `busy` out 1: a grant is held (state GRANT).
- `timeout` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- State machine with two states: IDLE and GRANT. Registers: `state`, `grant_id`, round-robin pointer `rr_ptr`, stall counter `stall_cnt` (width $clog2(TIMEOUT_CYCLES+1)), and `timeout`.
- **IDLE behaviour**
  - `m_valid`=0 and all `s_ready`=0.
  - If any `s_valid` is high, select the first asserted source at or after `rr_ptr`, searching upward with wrap modulo NUM_SRC.
  - Register the selection into `grant_id`, clear `stall_cnt`, and go to GRANT.
- **GRANT behaviour**
  - Datapath is combinational from the registered `grant_id`: `m_valid`=`s_valid[g]`, `m_data`=`s_data[g]`, `s_ready[g]`=`m_ready`. All other `s_ready` are 0.
  - A handshake is `s_valid[g]` & `m_ready`.
  - Handshake with `s_last[g]`=1: go to IDLE and set `rr_ptr`=(g+1) mod NUM_SRC.
  - Any handshake clears `stall_cnt`.
  - A cycle with `s_valid[g]`=0 increments `stall_cnt`.
  - Cycles with `s_valid[g]`=1 and `m_ready`=0 do not count. Backpressure from the UART is never a source stall.
  - When TIMEOUT_CYCLES≠0 and `stall_cnt` reaches TIMEOUT_CYCLES-1 while `s_valid[g]`=0:
    - go to IDLE;
    - set `rr_ptr`=(g+1) mod NUM_SRC;
    - pulse `timeout` for one cycle.
  - The revoked source's later bytes are arbitrated as a new message.
- **Boundary rules**
  - `s_valid` deasserting mid-message does not release the grant; only `last` or the timeout does.
  - Requests from other sources during GRANT are ignored until IDLE.
  - A handshake and the timeout threshold in the same cycle cannot both occur, because the timeout requires `s_valid[g]`=0.
  - NUM_SRC not a power of two: pointer wrap uses explicit compare, never bit truncation.
- **Reset** (asynchronous, any time, including mid-message): `state`=IDLE, `grant_id`=0, `rr_ptr`=0, `stall_cnt`=0, `timeout`=0. A partially sent message is abandoned.

## Timing
- Reset values of outputs: `m_valid`=0, `m_data`=`s_data[7:0]` (don't-care while `m_valid`=0), `s_ready`=0, `grant_id`=0, `busy`=0, `timeout`=0.
- Arbitration latency is 1 cycle: `s_valid` sampled high in IDLE at edge N gives `busy`=1 and `m_valid` from cycle N+1.
- Throughput inside a message is 1 byte/cycle when `m_ready` is held high.
- Inter-message gap is exactly one IDLE cycle after the `last` handshake, including back-to-back messages from different sources.
- `timeout` is asserted in the first IDLE cycle after the revoking edge.
- Timeout fires on the edge ending the TIMEOUT_CYCLES-th consecutive non-valid cycle.
- There is no combinational path from `s_valid` to `s_ready`. The only combinational path is `m_ready` → `s_ready[g]`.

## Test plan
- **Reset:** `rst_n`=0 mid-message while `m_valid`=1 → `busy`, `m_valid`, `s_ready`, `timeout` all 0 immediately; `rr_ptr`=0 afterwards.
- **Single message:** source 0 sends 3 bytes 0x48,0x69,0x0A (`last` on 0x0A) with `m_ready`=1 → `m_valid` high for cycles 1–3 after request, bytes in order, `busy` drops the cycle after 0x0A.
- **Interleave/fairness:** sources 0 and 1 both request continuously with 2-byte messages → grants alternate 0,1,0,1; no byte of source 1 appears between source 0's bytes; one idle cycle between messages.
- **Backpressure:** `m_ready` low for 50 cycles mid-message with `s_valid` held, TIMEOUT_CYCLES=8 → no timeout, `m_data` stable, message completes intact.
- **Stall timeout:** TIMEOUT_CYCLES=8; source 1 sends 1 byte without `last` then drops `s_valid`; source 0 is waiting → `timeout` pulses once after 8 stall cycles, then source 0 is granted next.
- **Wrap with NUM_SRC=3:** only source 2 requests, then source 0 and source 2 request together → source 0 is granted (pointer wrapped 2→0).
